// File: rtl/seg_display_driver.sv
// Four-digit multiplexed 7-segment driver with anti-ghosting blank gaps.
// Scans digits 3,2,1,0 from a load-able 16-bit shadow message; all display
// outputs come straight from flip-flops.
module seg_display_driver #(
  parameter int unsigned DIGIT_CYCLES = 16,
  parameter int unsigned BLANK_CYCLES = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] msg,
  input  logic        load,
  output logic [3:0]  an,
  output logic [6:0]  seg,
  output logic        dp
);

  localparam int unsigned MAX_CYC    = (DIGIT_CYCLES > BLANK_CYCLES) ? DIGIT_CYCLES : BLANK_CYCLES;
  localparam int unsigned CNT_W      = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;
  localparam int unsigned DIGIT_LAST = DIGIT_CYCLES - 1;
  localparam int unsigned BLANK_LAST = (BLANK_CYCLES > 0) ? BLANK_CYCLES - 1 : 0;

  localparam logic [0:0] ST_BLANK = 1'b0;
  localparam logic [0:0] ST_DRIVE = 1'b1;
  // With no blank gap the scan lives permanently in DRIVE.
  localparam logic [0:0] ST_AFTER_DRIVE = (BLANK_CYCLES == 0) ? ST_DRIVE : ST_BLANK;

  logic [0:0]       state_q, state_d;
  logic [1:0]       idx_q, idx_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [15:0]      shadow_q, shadow_d;
  logic [3:0]       an_q, an_d;
  logic [6:0]       seg_q, seg_d;

  // Hex to active-low a..g segment pattern.
  function automatic logic [6:0] seg_decode(input logic [3:0] code);
    logic [6:0] s;
    case (code)
      4'h0: s = 7'b0000001;
      4'h1: s = 7'b1001111;
      4'h2: s = 7'b0010010;
      4'h3: s = 7'b0000110;
      4'h4: s = 7'b1001100;
      4'h5: s = 7'b0100100;
      4'h6: s = 7'b0100000;
      4'h7: s = 7'b0001111;
      4'h8: s = 7'b0000000;
      4'h9: s = 7'b0000100;
      4'hA: s = 7'b0001000;
      4'hB: s = 7'b1100000;
      4'hC: s = 7'b0110001;
      4'hD: s = 7'b1000010;
      4'hE: s = 7'b0110000;
      default: s = 7'b0111000;
    endcase
    return s;
  endfunction

  // State, shadow and output registers; reset wins over load.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= ST_AFTER_DRIVE;
      idx_q    <= 2'd3;
      cnt_q    <= '0;
      shadow_q <= '0;
      an_q     <= 4'hF;
      seg_q    <= 7'h7F;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      cnt_q    <= cnt_d;
      shadow_q <= shadow_d;
      an_q     <= an_d;
      seg_q    <= seg_d;
    end
  end

  // Scan sequencing and next output values from the current slot position.
  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    cnt_d    = cnt_q;
    shadow_d = load ? msg : shadow_q;
    an_d     = 4'hF;
    seg_d    = seg_decode(shadow_q[{idx_q, 2'b00} +: 4]);

    if (state_q == ST_BLANK) begin
      if (cnt_q == CNT_W'(BLANK_LAST)) begin
        state_d = ST_DRIVE;
        cnt_d   = '0;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end else begin
      an_d = ~(4'b0001 << idx_q);
      if (cnt_q == CNT_W'(DIGIT_LAST)) begin
        state_d = ST_AFTER_DRIVE;
        cnt_d   = '0;
        idx_d   = idx_q - 2'd1;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  assign an  = an_q;
  assign seg = seg_q;
  assign dp  = 1'b1;

endmodule

// File: tb/tb_seg_display_driver.sv
// Bench for seg_display_driver: default build plus a BLANK=0/DIGIT=1 build,
// both checked every cycle against a slot-arithmetic model of the scan.
module tb_seg_display_driver;

  localparam int B  = 2;
  localparam int D  = 16;
  localparam int B2 = 0;
  localparam int D2 = 1;

  logic        clk = 1'b0;
  logic        reset;
  logic        load;
  logic [15:0] msg;
  logic [3:0]  an, an2;
  logic [6:0]  seg, seg2;
  logic        dp, dp2;

  int n_checks = 0;
  int n_fail   = 0;

  // Model state: k = cycles since reset release, sh = modelled shadow.
  int          k;
  logic [15:0] sh;
  logic [3:0]  exp_an, exp_an2;
  logic [6:0]  exp_seg, exp_seg2;

  logic [6:0] seg_tbl [16] = '{
    7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
    7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
    7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
    7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000
  };

  always #5 clk = ~clk;

  seg_display_driver u_dut (
    .clk(clk), .reset(reset), .msg(msg), .load(load),
    .an(an), .seg(seg), .dp(dp)
  );

  seg_display_driver #(.DIGIT_CYCLES(D2), .BLANK_CYCLES(B2)) u_b0 (
    .clk(clk), .reset(reset), .msg(msg), .load(load),
    .an(an2), .seg(seg2), .dp(dp2)
  );

  function automatic logic [3:0] nib(input logic [15:0] v, input int d);
    return 4'((v >> (4 * d)) & 16'hF);
  endfunction

  // Apply one cycle of inputs, then derive expected outputs for that cycle.
  task automatic tick(input logic rst, input logic ld, input logic [15:0] m);
    int p, slot, off, d;
    reset = rst;
    load  = ld;
    msg   = m;
    @(posedge clk);
    #1;
    if (rst) begin
      k = 0; sh = 16'h0000;
      exp_an = 4'hF; exp_seg = 7'h7F; exp_an2 = 4'hF; exp_seg2 = 7'h7F;
    end else begin
      k++;
      p = (k - 1) % (4 * (B + D)); slot = p / (B + D); off = p % (B + D); d = 3 - slot;
      exp_an  = (off < B) ? 4'hF : (4'hF ^ 4'(1 << d));
      exp_seg = seg_tbl[nib(sh, d)];
      p = (k - 1) % (4 * (B2 + D2)); slot = p / (B2 + D2); off = p % (B2 + D2); d = 3 - slot;
      exp_an2  = (off < B2) ? 4'hF : (4'hF ^ 4'(1 << d));
      exp_seg2 = seg_tbl[nib(sh, d)];
      if (ld) sh = m;
    end
  endtask

  task automatic test_reset();
    for (int i = 0; i < 3; i++) begin
      tick(1'b1, 1'b0, 16'h0);
      n_checks++; if (an !== 4'hF) begin n_fail++; $display("FAIL reset_an: got %b expected 1111", an); end
      n_checks++; if (seg !== 7'h7F) begin n_fail++; $display("FAIL reset_seg: got %b expected 1111111", seg); end
      n_checks++; if (dp !== 1'b1) begin n_fail++; $display("FAIL reset_dp: got %b expected 1", dp); end
    end
  endtask

  task automatic test_scan_1234();
    tick(1'b1, 1'b0, 16'h0);
    for (int i = 1; i <= 80; i++) begin
      tick(1'b0, (i == 1), 16'h1234);
      n_checks++; if (an !== exp_an) begin n_fail++; $display("FAIL scan_an cycle %0d: got %b expected %b", k, an, exp_an); end
      n_checks++; if (seg !== exp_seg) begin n_fail++; $display("FAIL scan_seg cycle %0d: got %b expected %b", k, seg, exp_seg); end
      if (k == 3) begin
        n_checks++; if (an !== 4'b0111 || seg !== 7'b1001111) begin n_fail++; $display("FAIL scan_d3_start: got an=%b seg=%b expected an=0111 seg=1001111", an, seg); end
      end
      if (k == 19 || k == 20) begin
        n_checks++; if (an !== 4'hF) begin n_fail++; $display("FAIL scan_gap cycle %0d: got %b expected 1111", k, an); end
      end
      if (k == 21) begin
        n_checks++; if (an !== 4'b1011 || seg !== 7'b0010010) begin n_fail++; $display("FAIL scan_d2_start: got an=%b seg=%b expected an=1011 seg=0010010", an, seg); end
      end
      if (k == 57) begin
        n_checks++; if (an !== 4'b1110 || seg !== 7'b1001100) begin n_fail++; $display("FAIL scan_d0_start: got an=%b seg=%b expected an=1110 seg=1001100", an, seg); end
      end
      if (k == 75) begin
        n_checks++; if (an !== 4'b0111) begin n_fail++; $display("FAIL scan_wrap: got %b expected 0111", an); end
      end
    end
  endtask

  task automatic test_mid_load();
    tick(1'b1, 1'b0, 16'h0);
    for (int i = 1; i <= 22; i++) begin
      tick(1'b0, (i == 12), 16'h8888);
      n_checks++; if (an !== exp_an) begin n_fail++; $display("FAIL midload_an cycle %0d: got %b expected %b", k, an, exp_an); end
      n_checks++; if (seg !== exp_seg) begin n_fail++; $display("FAIL midload_seg cycle %0d: got %b expected %b", k, seg, exp_seg); end
      if (k == 13) begin
        n_checks++; if (seg !== 7'b0000000) begin n_fail++; $display("FAIL midload_new: got %b expected 0000000", seg); end
      end
      if (k == 18) begin
        n_checks++; if (an !== 4'b0111) begin n_fail++; $display("FAIL midload_slot_end: got %b expected 0111", an); end
      end
      if (k == 19) begin
        n_checks++; if (an !== 4'hF) begin n_fail++; $display("FAIL midload_blank: got %b expected 1111", an); end
      end
    end
  endtask

  task automatic test_reset_mid_drive();
    tick(1'b1, 1'b0, 16'h0);
    tick(1'b0, 1'b1, 16'h1234);
    while (k < 45) tick(1'b0, 1'b0, 16'h0);
    n_checks++; if (an !== 4'b1101) begin n_fail++; $display("FAIL rmd_pre: got %b expected 1101", an); end
    tick(1'b1, 1'b0, 16'h0);
    n_checks++; if (an !== 4'hF || seg !== 7'h7F) begin n_fail++; $display("FAIL rmd_reset: got an=%b seg=%b expected an=1111 seg=1111111", an, seg); end
    for (int i = 1; i <= 25; i++) begin
      tick(1'b0, 1'b0, 16'h0);
      n_checks++; if (an !== exp_an) begin n_fail++; $display("FAIL rmd_an cycle %0d: got %b expected %b", k, an, exp_an); end
      n_checks++; if (seg !== exp_seg) begin n_fail++; $display("FAIL rmd_seg cycle %0d: got %b expected %b", k, seg, exp_seg); end
      if (k == 3) begin
        n_checks++; if (an !== 4'b0111 || seg !== 7'b0000001) begin n_fail++; $display("FAIL rmd_restart: got an=%b seg=%b expected an=0111 seg=0000001", an, seg); end
      end
    end
  endtask

  task automatic test_load_reset();
    tick(1'b1, 1'b1, 16'hFFFF);
    n_checks++; if (an !== 4'hF || seg !== 7'h7F) begin n_fail++; $display("FAIL lr_reset: got an=%b seg=%b expected an=1111 seg=1111111", an, seg); end
    for (int i = 1; i <= 3; i++) begin
      tick(1'b0, 1'b0, 16'h0);
      if (k == 1) begin
        n_checks++; if (an2 !== 4'b0111 || seg2 !== 7'b0000001) begin n_fail++; $display("FAIL lr_b0_first: got an=%b seg=%b expected an=0111 seg=0000001", an2, seg2); end
      end
    end
    n_checks++; if (an !== 4'b0111 || seg !== 7'b0000001) begin n_fail++; $display("FAIL lr_first_drive: got an=%b seg=%b expected an=0111 seg=0000001", an, seg); end
  endtask

  task automatic test_back_to_back();
    logic [3:0] seq [4] = '{4'b0111, 4'b1011, 4'b1101, 4'b1110};
    tick(1'b1, 1'b0, 16'h0);
    for (int i = 0; i < 8; i++) begin
      tick(1'b0, 1'b0, 16'h0);
      n_checks++; if (an2 !== seq[i % 4]) begin n_fail++; $display("FAIL b2b_an cycle %0d: got %b expected %b", k, an2, seq[i % 4]); end
    end
  endtask

  task automatic test_random();
    logic rst, ld;
    logic [15:0] m;
    tick(1'b1, 1'b0, 16'h0);
    for (int i = 0; i < 1000; i++) begin
      rst = ($urandom_range(0, 199) == 0);
      ld  = ($urandom_range(0, 3) == 0);
      m   = 16'($urandom);
      tick(rst, ld, m);
      n_checks++; if (an !== exp_an) begin n_fail++; $display("FAIL rand_an cycle %0d: got %b expected %b", k, an, exp_an); end
      n_checks++; if (seg !== exp_seg) begin n_fail++; $display("FAIL rand_seg cycle %0d: got %b expected %b", k, seg, exp_seg); end
      n_checks++; if (an2 !== exp_an2) begin n_fail++; $display("FAIL rand_an2 cycle %0d: got %b expected %b", k, an2, exp_an2); end
      n_checks++; if (seg2 !== exp_seg2) begin n_fail++; $display("FAIL rand_seg2 cycle %0d: got %b expected %b", k, seg2, exp_seg2); end
      n_checks++; if ($countones(~an2) > 1 || $countones(~an) > 1) begin n_fail++; $display("FAIL rand_onehot cycle %0d: got an=%b an2=%b expected at most one low", k, an, an2); end
      n_checks++; if (dp !== 1'b1 || dp2 !== 1'b1) begin n_fail++; $display("FAIL rand_dp: got %b %b expected 1 1", dp, dp2); end
    end
  endtask

  initial begin
    reset = 1'b1;
    load  = 1'b0;
    msg   = 16'h0;
    k     = 0;
    sh    = 16'h0;
    test_reset();
    test_scan_1234();
    test_mid_load();
    test_reset_mid_drive();
    test_load_reset();
    test_back_to_back();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/seg_display_driver.md
SEG_DISPLAY_DRIVER -- requirements
Module: seg_display_driver

Interface
REQ-001 SHALL have parameter DIGIT_CYCLES, default 16: clk cycles one digit is driven per scan slot; legal range 1..65535.
REQ-002 SHALL have parameter BLANK_CYCLES, default 2: clk cycles all anodes are off before each slot (anti-ghosting); legal range 0..255.
REQ-003 SHALL have port clk  input  1  sole clock; all state changes on posedge clk.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset, driven by the synchronized reset from the reset synchronizer stage.
REQ-005 SHALL have port msg  input  16  four 4-bit character codes; msg[15:12] is digit 3 (leftmost), msg[3:0] is digit 0 (rightmost).
REQ-006 SHALL have port load  input  1  when high on a posedge, msg is captured into the internal shadow register.
REQ-007 SHALL have port an  output  4  active-low anode enables; an[3] is the leftmost digit.
REQ-008 SHALL have port seg  output  7  active-low segments, seg[6]=a through seg[0]=g.
REQ-009 SHALL have port dp  output  1  active-low decimal point, constantly 1 (off).

Function
REQ-010 an and seg SHALL be driven directly from flip-flops, with no combinational path from any input.
REQ-011 A 16-bit shadow register SHALL hold the displayed message; load=1 updates it on that posedge, and the new value SHALL affect seg from the next cycle; load SHALL NOT restart or shift the scan.
REQ-012 The scan FSM SHALL have states BLANK and DRIVE, a 2-bit digit index, and a slot counter sized for max(DIGIT_CYCLES, BLANK_CYCLES).
REQ-013 BLANK: an=1111 for exactly BLANK_CYCLES consecutive cycles, with seg already showing the decoded code of the current digit index; it then moves to DRIVE with the counter cleared.
REQ-014 DRIVE: an is low only on the bit for the current index, for exactly DIGIT_CYCLES consecutive cycles; it then moves to BLANK with the index decremented.
REQ-015 Scan order SHALL be 3,2,1,0,3,..., with the index wrapping from 0 to 3; the full scan period is 4*(BLANK_CYCLES+DIGIT_CYCLES) cycles.
REQ-016 When BLANK_CYCLES=0, the BLANK state SHALL be skipped entirely: DRIVE slots are back-to-back and an never reads 1111 after the first post-reset cycle.
REQ-017 an SHALL never have more than one bit low in any cycle.
REQ-018 Decode (hex, active-low, a..g): 0=0000001, 1=1001111, 2=0010010, 3=0000110, 4=1001100, 5=0100100, 6=0100000, 7=0001111, 8=0000000, 9=0000100, A=0001000, B=1100000, C=0110001, D=1000010, E=0110000, F=0111000.
REQ-019 seg SHALL change only when the index or shadow register changes, never mid-DRIVE except on a load.
REQ-020 If load and reset are both high in the same cycle, reset SHALL win and the shadow SHALL become 0000.

Reset
REQ-021 While reset=1 at a posedge: shadow=16'h0000, state=BLANK (DRIVE if BLANK_CYCLES=0), index=3, counter=0, an=1111, seg=1111111, dp=1.
REQ-022 Reset asserted mid-DRIVE or mid-BLANK SHALL take effect at the next posedge with no partial slot completion.
REQ-023 The first posedge with reset=0 SHALL count as cycle 1 of the digit-3 BLANK slot.

Verification
REQ-024 Reset held 3 cycles with defaults -> an=1111, seg=1111111, dp=1 in every cycle while reset is asserted.
REQ-025 Release reset, load msg=16'h1234 on cycle 1 -> cycles 1-2: an=1111; cycles 3-18: an=0111, seg=1001111; cycles 19-20: an=1111; cycles 21-36: an=1011, seg=0010010; digit 0 shows seg=1001100 with an=1110; digit 3 recurs at cycle 75.
REQ-026 load msg=16'h8888 at cycle 10 of a DRIVE slot -> seg=0000000 from cycle 11, and the slot still ends on its original cycle.
REQ-027 Assert reset for 1 cycle mid-DRIVE of digit 1 -> next cycle an=1111, seg=1111111, shadow=0000; the scan restarts at digit 3 per REQ-023.
REQ-028 Build with BLANK_CYCLES=0, DIGIT_CYCLES=1 -> an cycles 0111,1011,1101,1110 on consecutive cycles; a checker confirms REQ-017 for 1000 cycles.
REQ-029 load and reset both high in one cycle with msg=16'hFFFF -> shadow stays 0000, and the first driven digit shows seg=0000001.
